// File: rtl/pipe_adder_pkg.sv
// Shared types and configuration helpers for the pipelined add/subtract unit.
package pipe_adder_pkg;

    localparam int DEFAULT_WIDTH  = 32;
    localparam int DEFAULT_STAGES = 4;

    typedef struct packed {
        logic carry;
        logic overflow;
        logic zero;
    } flags_t;

    localparam flags_t FLAGS_NONE = '0;

    // WIDTH must split evenly into STAGES slices of at least one bit each.
    function automatic bit cfg_legal(input int width, input int stages);
        return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
    endfunction

    function automatic int slice_width(input int width, input int stages);
        return (stages >= 1) ? (width / stages) : width;
    endfunction

endpackage

// File: rtl/pipe_adder_if.sv
// Operand/result handshake bundle for pipe_adder; master drives operands and consumes results.
interface pipe_adder_if
    import pipe_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             carry;
    logic             overflow;
    logic             zero;

    modport master (
        output in_valid, a, b, sub, out_ready,
        input  in_ready, out_valid, s, carry, overflow, zero
    );

    modport slave (
        input  in_valid, a, b, sub, out_ready,
        output in_ready, out_valid, s, carry, overflow, zero
    );

endinterface

// File: rtl/pipe_adder_slice.sv
// adder_slice: one CW-bit carry-chained slice of the pipelined adder, purely combinational.
module adder_slice
    import pipe_adder_pkg::*;
#(
    parameter int CW = DEFAULT_WIDTH / DEFAULT_STAGES
) (
    input  logic [CW-1:0] a,
    input  logic [CW-1:0] b,
    input  logic          cin,
    output logic [CW-1:0] s,
    output logic          cout
);

    assign {cout, s} = {1'b0, a} + {1'b0, b} + {{CW{1'b0}}, cin};

endmodule

// File: rtl/pipe_adder.sv
// pipe_adder: WIDTH-bit add/subtract split into STAGES registered carry-chained slices.
// Status flags (carry/overflow/zero) exist only when PIPE_ADDER_FLAGS_EN is defined.
module pipe_adder
    import pipe_adder_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int STAGES = DEFAULT_STAGES
) (
    input logic         clk,
    input logic         rst,
    pipe_adder_if.slave bus
);

    localparam int CW   = slice_width(WIDTH, STAGES);
    localparam int LAST = STAGES - 1;

    if (!cfg_legal(WIDTH, STAGES)) begin : g_bad_cfg
        $error("pipe_adder: WIDTH (%0d) must be a nonzero multiple of STAGES (%0d)", WIDTH, STAGES);
    end

    logic adv;
    flags_t flags;

    logic [WIDTH-1:0] opIn     [STAGES];
    logic [WIDTH-1:0] bIn      [STAGES];
    logic             cIn      [STAGES];
    logic [CW-1:0]    sliceSum [STAGES];

    logic [WIDTH-1:0] work_d  [STAGES];
    logic [WIDTH-1:0] work_q  [STAGES];
    logic [WIDTH-1:0] bRest_d [STAGES];
    logic [WIDTH-1:0] bRest_q [STAGES];
    logic             carry_d [STAGES];
    logic             carry_q [STAGES];
    logic             valid_d [STAGES];
    logic             valid_q [STAGES];

    // The work vector rotates right by one slice per stage: the next unprocessed A slice
    // sits at the bottom while finished sum slices enter at the top, so after the last
    // stage it holds the complete result in natural bit order.
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_entry
            assign opIn[k]    = bus.a;
            assign bIn[k]     = bus.sub ? ~bus.b : bus.b;
            assign cIn[k]     = bus.sub;
            assign valid_d[k] = bus.in_valid;
        end else begin : g_chain
            assign opIn[k]    = work_q[k-1];
            assign bIn[k]     = bRest_q[k-1];
            assign cIn[k]     = carry_q[k-1];
            assign valid_d[k] = valid_q[k-1];
        end

        adder_slice #(
            .CW(CW)
        ) u_slice (
            .a   (opIn[k][CW-1:0]),
            .b   (bIn[k][CW-1:0]),
            .cin (cIn[k]),
            .s   (sliceSum[k]),
            .cout(carry_d[k])
        );

        assign work_d[k]  = (opIn[k] >> CW) | (WIDTH'(sliceSum[k]) << (WIDTH - CW));
        assign bRest_d[k] = bIn[k] >> CW;
    end

    // Whole pipeline advances in lockstep; bubbles stay in place during a stall.
    assign adv = !valid_q[LAST] || bus.out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                work_q[k]  <= '0;
                bRest_q[k] <= '0;
                carry_q[k] <= 1'b0;
                valid_q[k] <= 1'b0;
            end
        end else if (adv) begin
            for (int k = 0; k < STAGES; k++) begin
                work_q[k]  <= work_d[k];
                bRest_q[k] <= bRest_d[k];
                carry_q[k] <= carry_d[k];
                valid_q[k] <= valid_d[k];
            end
        end
    end

`ifdef PIPE_ADDER_FLAGS_EN
    logic signA_d [STAGES];
    logic signA_q [STAGES];
    logic signB_d [STAGES];
    logic signB_q [STAGES];

    // Operand sign bits are captured at entry because the work vector overwrites them.
    for (genvar k = 0; k < STAGES; k++) begin : g_sign
        if (k == 0) begin : g_entry
            assign signA_d[k] = bus.a[WIDTH-1];
            assign signB_d[k] = bIn[k][WIDTH-1];
        end else begin : g_chain
            assign signA_d[k] = signA_q[k-1];
            assign signB_d[k] = signB_q[k-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                signA_q[k] <= 1'b0;
                signB_q[k] <= 1'b0;
            end
        end else if (adv) begin
            for (int k = 0; k < STAGES; k++) begin
                signA_q[k] <= signA_d[k];
                signB_q[k] <= signB_d[k];
            end
        end
    end

    assign flags.carry    = carry_q[LAST];
    assign flags.overflow = (signA_q[LAST] == signB_q[LAST]) &&
                            (work_q[LAST][WIDTH-1] != signA_q[LAST]);
    assign flags.zero     = valid_q[LAST] && (work_q[LAST] == '0);
`else
    assign flags = FLAGS_NONE;
`endif

    assign bus.in_ready  = adv;
    assign bus.out_valid = valid_q[LAST];
    assign bus.s         = work_q[LAST];
    assign bus.carry     = flags.carry;
    assign bus.overflow  = flags.overflow;
    assign bus.zero      = flags.zero;

endmodule
